logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, registered bitwise logic unit. It generalises the fixed 16-bit OR
//   slice to WIDTH bits and 8 selectable operations.
//   Sits in the datapath ALU between the operand mux and the writeback stage.
//   Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so
//   writeback stalls never drop a result.
//   Produces the result plus zero and parity flags for the flag register.
// PARAMETERS
//   WIDTH      16   operand/result width in bits, >= 2
// PORTS
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   in_valid   in   1      operands a, b and op are valid this cycle
//   in_ready   out  1      unit accepts operands this cycle
//   op         in   3      operation select (encodings in logic_unit_pkg)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result and flags are valid
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   parity     out  1      XOR-reduction of result (odd parity = 1)
//   op_count   out  32     results delivered (present only with LOGIC_UNIT_STATS_EN)
// BEHAVIOUR
//   - Op encodings: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (a & ~b), 7 PASSA.
//   - Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
//   - Latency: an accepted operand set appears on result no earlier than the next
//     cycle. Results leave in strict acceptance order.
//   - Flags are computed from the stored result and are always consistent with it.
//   - State machine: occupancy state, EMPTY -> HALF -> FULL, with an output
//     register (OREG) and a skid register (SREG).
//       EMPTY: out_valid=0. Accept -> OREG, go to HALF.
//       HALF:  out_valid=1.
//              Accept & deliver -> OREG takes the new operands, stay in HALF.
//              Accept & !deliver -> SREG takes the new operands, go to FULL.
//              Deliver & !accept -> go to EMPTY.
//              Neither -> hold.
//       FULL:  out_valid=1, in_ready=0.
//              Deliver -> OREG <= SREG, go to HALF.
//              No deliver -> hold both registers.
//   - in_ready is a registered output: 1 in EMPTY/HALF, 0 in FULL. There is no
//     combinational path from out_ready to in_ready.
//   - While out_valid=1 and out_ready=0, result, zero and parity do not change.
//   - in_valid while in_ready=0 is ignored; the operands are not captured.
//   - Reset (any time, including mid-transfer):
//       state=EMPTY, out_valid=0, in_ready=1 (from the first cycle after reset
//       deasserts), result=0, zero=1, parity=0, op_count=0.
//       Buffered entries are discarded.
//   - Widths: all ops are WIDTH-bit bitwise operations. There is no carry, and
//     nothing is truncated or extended.
// CONFIGURATION
//   LOGIC_UNIT_STATS_EN defined:
//     - op_count port exists.
//     - op_count increments by 1 on every deliver.
//     - At 2^32-1 it wraps to 0.
//   LOGIC_UNIT_STATS_EN undefined: no op_count port, no counter logic.
// STRUCTURE
//   - logic_unit_pkg holds:
//       - localparams OP_AND..OP_PASSA (3-bit)
//       - occupancy state encodings ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2
//   - Sub-module logic_op_comb holds the purely combinational WIDTH-bit op mux,
//     instantiated once on the input side. Only (result) is stored; flags are
//     derived from the stored result.
// TESTING
//   1. Reset, then a=16'hF0F0, b=16'h0FF0, op=OR, out_ready=1
//      -> next cycle result=16'hFFF0, zero=0, parity=0.
//   2. Sweep all 8 ops with a=16'h00FF, b=16'h0F0F
//      -> AND 000F, OR 0FFF, XOR 0FF0, NOR F000, NAND FFF0, XNOR F00F,
//         ANDN 00F0, PASSA 00FF.
//   3. Hold out_ready=0 and offer 3 back-to-back ops
//      -> first two are accepted, in_ready=0 after the second; result holds
//         the first. Then out_ready=1 -> results arrive in order, no loss.
//   4. a=b=16'hAAAA, op=XOR -> result=0, zero=1, parity=0.
//      op=PASSA, a=16'h0001 -> parity=1.
//   5. Assert reset while in FULL -> out_valid=0, result=0, zero=1, in_ready=1
//      after release; op_count=0.
//   6. With LOGIC_UNIT_STATS_EN, deliver 5 results with random stalls
//      -> op_count=5. Preload the counter to 32'hFFFFFFFF, deliver 1 -> op_count=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined bitwise logic unit.
//   OP_*        3-bit operation select encodings seen on the op port
//   occState_t  occupancy state of the output/skid register pair
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  // Operation select encodings for the op port.
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_ANDN  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  // How many results are held: none, only the output register, or both
  // the output register and the skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } occState_t;

endpackage

// File: rtl/logic_op_comb.sv
// ---------------------------------------------------------------------------
// logic_op_comb
// Purely combinational WIDTH-bit bitwise operation mux.
// Ports:
//   i_op  in   3      operation select (OP_* from logic_unit_pkg)
//   i_a   in   WIDTH  operand A
//   i_b   in   WIDTH  operand B
//   o_y   out  WIDTH  bitwise result, same width as the operands
// ---------------------------------------------------------------------------
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Select one of the eight bitwise operations. Every operation works bit
  // by bit, so there is no carry and the width never changes.
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:   o_y = i_a & i_b;
      OP_OR:    o_y = i_a | i_b;
      OP_XOR:   o_y = i_a ^ i_b;
      OP_NOR:   o_y = ~(i_a | i_b);
      OP_NAND:  o_y = ~(i_a & i_b);
      OP_XNOR:  o_y = ~(i_a ^ i_b);
      OP_ANDN:  o_y = i_a & ~i_b;
      OP_PASSA: o_y = i_a;
      default:  o_y = i_a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with valid/ready handshakes on both sides
// and a 2-entry skid buffer (output register + skid register), so a stalled
// consumer never causes a result to be dropped. Zero and parity flags are
// derived from the stored result.
// Optional feature macro: LOGIC_UNIT_STATS_EN adds the op_count port and a
// 32-bit delivered-results counter.
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      unit accepts operands (registered)
//   op         in   3      operation select
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   parity     out  1      XOR-reduction of result
//   op_count   out  32     results delivered (LOGIC_UNIT_STATS_EN only)
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [31:0]      op_count
`endif
);

  occState_t        r_state;
  logic             r_inReady;
  logic             r_outValid;
  logic [WIDTH-1:0] r_oreg;
  logic [WIDTH-1:0] r_sreg;

  logic [WIDTH-1:0] w_opResult;
  logic             w_accept;
  logic             w_deliver;

  // The op mux sits on the input side so only the finished result is
  // stored; the flags are recomputed from whatever sits in the output
  // register and therefore can never disagree with it.
  logic_op_comb #(
    .WIDTH (WIDTH)
  ) u_opComb (
    .i_op (op),
    .i_a  (a),
    .i_b  (b),
    .o_y  (w_opResult)
  );

  // Handshake events for this cycle, using the registered ready/valid so
  // out_ready never reaches in_ready combinationally.
  assign w_accept  = in_valid & r_inReady;
  assign w_deliver = r_outValid & out_ready;

  // Occupancy state machine. The output register always holds the oldest
  // result; the skid register only fills when a new operand set arrives
  // while the consumer is stalling, and drains into the output register on
  // the next deliver. in_ready and out_valid are registered alongside the
  // state so both are plain flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_oreg     <= '0;
      r_sreg     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_oreg     <= w_opResult;
            r_outValid <= 1'b1;
            r_state    <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (w_accept && w_deliver) begin
            r_oreg <= w_opResult;
          end else if (w_accept) begin
            r_sreg    <= w_opResult;
            r_inReady <= 1'b0;
            r_state   <= ST_FULL;
          end else if (w_deliver) begin
            r_outValid <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_deliver) begin
            r_oreg    <= r_sreg;
            r_inReady <= 1'b1;
            r_state   <= ST_HALF;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign result    = r_oreg;
  assign zero      = ~|r_oreg;
  assign parity    = ^r_oreg;

`ifdef LOGIC_UNIT_STATS_EN
  logic [31:0] r_opCount;

  // Count every delivered result; the natural 32-bit rollover gives the
  // wrap from all-ones back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opCount <= '0;
    end else if (w_deliver) begin
      r_opCount <= r_opCount + 32'd1;
    end
  end

  assign op_count = r_opCount;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Self-checking bench for logic_unit_pipe: directed cases plus randomized
// traffic, compared against a truth-table/queue reference model.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int WIDTH = 16;

  // Per-op truth table: bit index {a_bit, b_bit} gives the result bit.
  localparam logic [3:0] TRUTH [8] = '{
    4'b1000,
    4'b1110,
    4'b0110,
    4'b0001,
    4'b0111,
    4'b1001,
    4'b0100,
    4'b1100
  };

  // Expected sweep results for a=00FF, b=0F0F, ops 0..7.
  localparam logic [15:0] SWEEP [8] = '{
    16'h000F, 16'h0FFF, 16'h0FF0, 16'hF000,
    16'hFFF0, 16'hF00F, 16'h00F0, 16'h00FF
  };

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       op        = 3'd0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
`ifdef LOGIC_UNIT_STATS_EN
  logic [31:0]      op_count;
`endif

  int               testCount = 0;
  int               failCount = 0;
  logic [WIDTH-1:0] modelQ [$];
  logic [31:0]      modelDelivered = '0;

  always #5 clk = ~clk;

  logic_unit_pipe #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
`ifdef LOGIC_UNIT_STATS_EN
    .parity    (parity),
    .op_count  (op_count)
`else
    .parity    (parity)
`endif
  );

  // Reference operation: evaluate each bit through the op's truth table.
  function automatic logic [WIDTH-1:0] refOp(input logic [2:0] fOp,
                                             input logic [WIDTH-1:0] fA,
                                             input logic [WIDTH-1:0] fB);
    logic [WIDTH-1:0] y;
    logic [3:0]       tt;
    tt = TRUTH[fOp];
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = tt[{fA[i], fB[i]}];
    end
    return y;
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare the DUT's visible state with the model queue: up to two results
  // may be buffered, the oldest is on the output.
  task automatic checkModel(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, modelQ.size() < 2);
    checkOutput({tag, "_out_valid"}, out_valid, modelQ.size() > 0);
    if (modelQ.size() > 0) begin
      checkOutput({tag, "_result"}, result, modelQ[0]);
      checkOutput({tag, "_zero"}, zero, modelQ[0] == '0);
      checkOutput({tag, "_parity"}, parity, $countones(modelQ[0]) % 2);
    end
`ifdef LOGIC_UNIT_STATS_EN
    checkOutput({tag, "_op_count"}, op_count, modelDelivered);
`endif
  endtask

  // One clock of traffic: check at the falling edge, drive, update the
  // model at the rising edge, then settle so callers may inspect outputs.
  task automatic applyStimulus(input logic iv, input logic [2:0] iop,
                               input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib, input logic ordy);
    logic acc;
    logic del;
    @(negedge clk);
    checkModel("model");
    in_valid  = iv;
    op        = iop;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    acc = iv && (modelQ.size() < 2);
    del = (modelQ.size() > 0) && ordy;
    @(posedge clk);
    if (del) begin
      void'(modelQ.pop_front());
      modelDelivered = modelDelivered + 32'd1;
    end
    if (acc) modelQ.push_back(refOp(iop, ia, ib));
    #1;
  endtask

  // Asynchronous reset pulse, checked while asserted and after release.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput({tag, "_rst_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_rst_result"}, result, '0);
    checkOutput({tag, "_rst_zero"}, zero, 1'b1);
    checkOutput({tag, "_rst_parity"}, parity, 1'b0);
`ifdef LOGIC_UNIT_STATS_EN
    checkOutput({tag, "_rst_op_count"}, op_count, '0);
`endif
    @(negedge clk);
    reset = 1'b0;
    modelQ.delete();
    modelDelivered = '0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_post_in_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_post_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    doReset("t0");

    // Test 1: simple OR.
    applyStimulus(1'b1, 3'd1, 16'hF0F0, 16'h0FF0, 1'b1);
    checkOutput("t1_result", result, 16'hFFF0);
    checkOutput("t1_zero", zero, 1'b0);
    checkOutput("t1_parity", parity, 1'b0);

    // Test 2: sweep all ops with a consumer that never stalls.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 3'(k), 16'h00FF, 16'h0F0F, 1'b1);
      checkOutput($sformatf("t2_op%0d", k), result, SWEEP[k]);
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);

    // Test 3: stalled consumer, three back-to-back offers.
    applyStimulus(1'b1, 3'd0, 16'h00FF, 16'h0F0F, 1'b0);
    checkOutput("t3_first", result, 16'h000F);
    applyStimulus(1'b1, 3'd1, 16'h00FF, 16'h0F0F, 1'b0);
    checkOutput("t3_full_in_ready", in_ready, 1'b0);
    checkOutput("t3_hold", result, 16'h000F);
    applyStimulus(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0);
    checkOutput("t3_ignored_hold", result, 16'h000F);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    checkOutput("t3_second", result, 16'h0FFF);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    checkOutput("t3_drained", out_valid, 1'b0);

    // Test 4: flag corner cases.
    applyStimulus(1'b1, 3'd2, 16'hAAAA, 16'hAAAA, 1'b1);
    checkOutput("t4_xor_result", result, 16'h0000);
    checkOutput("t4_xor_zero", zero, 1'b1);
    checkOutput("t4_xor_parity", parity, 1'b0);
    applyStimulus(1'b1, 3'd7, 16'h0001, 16'hFFFF, 1'b1);
    checkOutput("t4_pass_parity", parity, 1'b1);
    checkOutput("t4_pass_zero", zero, 1'b0);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);

    // Randomized traffic with random stalls.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1)));
    end

    // Test 5: reset while both registers are occupied.
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    applyStimulus(1'b1, 3'd1, 16'h1234, 16'h4321, 1'b0);
    applyStimulus(1'b1, 3'd2, 16'h1234, 16'h4321, 1'b0);
    checkOutput("t5_full", in_ready, 1'b0);
    doReset("t5");

`ifdef LOGIC_UNIT_STATS_EN
    // Test 6: counter after five deliveries, then wrap from all-ones.
    guard = 0;
    while (modelDelivered < 32'd5 && guard < 200) begin
      applyStimulus(modelQ.size() + modelDelivered < 5, 3'($urandom_range(0, 7)),
                    WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      guard++;
    end
    checkOutput("t6_bound", guard < 200, 1'b1);
    checkOutput("t6_count5", op_count, 32'd5);
    @(negedge clk);
    dut.r_opCount = 32'hFFFF_FFFF;
    modelDelivered = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'h00FF, 1'b0);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    checkOutput("t6_wrap", op_count, 32'd0);
`else
    guard = 0;
`endif
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
